// File: rtl/lsu_mem_access_unit_if.sv
// ----------------------------------------------------------------------------
// lsu_mem_access_unit_if
// Groups the execute-side request/response handshake and the data-memory bus
// of the load/store unit.
//   slave  : the LSU itself (takes requests, drives the memory bus)
//   master : the environment (execute/writeback stages plus data memory)
// Request side : req_valid_i, req_ready_o, req_rd_i, req_wr_i, req_signed_i,
//                req_size_i, req_addr_i, req_wdata_i, req_rd_index_i
// Memory bus   : daddr_o, dwdata_o, dbe_o, drd_o, dwr_o, dready_i, drdata_i
// Response     : resp_valid_o, resp_rdata_o, resp_rd_index_o, resp_err_o
// XLEN and ADDR_W must match the parameters of the attached LSU instance.
// ----------------------------------------------------------------------------
interface lsu_mem_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int BE_W = XLEN / 8;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_rd_i;
  logic              req_wr_i;
  logic              req_signed_i;
  logic [1:0]        req_size_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [XLEN-1:0]   req_wdata_i;
  logic [4:0]        req_rd_index_i;

  logic [ADDR_W-1:0] daddr_o;
  logic [XLEN-1:0]   dwdata_o;
  logic [BE_W-1:0]   dbe_o;
  logic              drd_o;
  logic              dwr_o;
  logic              dready_i;
  logic [XLEN-1:0]   drdata_i;

  logic              resp_valid_o;
  logic [XLEN-1:0]   resp_rdata_o;
  logic [4:0]        resp_rd_index_o;
  logic              resp_err_o;

  modport slave (
    input  req_valid_i, req_rd_i, req_wr_i, req_signed_i, req_size_i,
           req_addr_i, req_wdata_i, req_rd_index_i, dready_i, drdata_i,
    output req_ready_o, daddr_o, dwdata_o, dbe_o, drd_o, dwr_o,
           resp_valid_o, resp_rdata_o, resp_rd_index_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_rd_i, req_wr_i, req_signed_i, req_size_i,
           req_addr_i, req_wdata_i, req_rd_index_i, dready_i, drdata_i,
    input  req_ready_o, daddr_o, dwdata_o, dbe_o, drd_o, dwr_o,
           resp_valid_o, resp_rdata_o, resp_rd_index_o, resp_err_o
  );
endinterface

// File: rtl/lsu_mem_access_unit.sv
// ----------------------------------------------------------------------------
// lsu_mem_access_unit
// Load/store unit between execute and the data-memory bus. Accepts one request
// per handshake, drives registered bus strobes until dready_i, aligns store
// data / byte enables to the addressed lane, extracts and sign/zero-extends
// load data and returns a one-cycle response.
// Ports:
//   clk_i    : clock
//   reset_i  : synchronous active-high reset (aborts any access in flight)
//   bus      : lsu_mem_access_unit_if.slave (request, memory bus, response)
// Parameters: XLEN (32 or 64), ADDR_W (byte-address width).
// Optional feature: define LSU_MISALIGN_SPLIT_EN to split misaligned accesses
// that cross an XLEN boundary into two bus beats (ACCESS -> ACCESS2). Without
// it every misaligned access is answered with resp_err_o and no bus beat.
// ----------------------------------------------------------------------------
module lsu_mem_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  lsu_mem_access_unit_if.slave bus
);
  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
`ifdef LSU_MISALIGN_SPLIT_EN
  // Lanes span two words so the part spilling past the boundary is kept.
  localparam int LANE_W = 2 * BE_W;
`else
  localparam int LANE_W = BE_W;
`endif
  localparam logic [6:0] SH_BYTE = 7'(XLEN - 8);
  localparam logic [6:0] SH_HALF = 7'(XLEN - 16);
  localparam logic [6:0] SH_WORD = 7'(XLEN - 32);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
`ifdef LSU_MISALIGN_SPLIT_EN
    ST_ACCESS2 = 2'd3,
`endif
    ST_RESP    = 2'd2
  } state_t;

  // Moves the low (8<<size) bits to the top and back, so the arithmetic
  // right shift replicates the sign bit without size-specific concatenations.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] data,
                                                  input logic [1:0]      size,
                                                  input logic            sgn);
    logic [6:0]      sh;
    logic [XLEN-1:0] tmp;
    logic [XLEN-1:0] res;
    case (size)
      2'd0:    sh = SH_BYTE;
      2'd1:    sh = SH_HALF;
      2'd2:    sh = SH_WORD;
      default: sh = 7'd0;
    endcase
    tmp = data << sh;
    if (sgn) begin
      res = $signed(tmp) >>> sh;
    end else begin
      res = tmp >> sh;
    end
    return res;
  endfunction

  state_t           state_r;
  logic             rd_r;
  logic             wr_r;
  logic             sgn_r;
  logic [1:0]       size_r;
  logic [OFF_W-1:0] off_r;
  logic [4:0]       idx_r;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic             split_r;
  logic [XLEN-1:0]  lo_data_r;
  logic [BE_W-1:0]  hi_be_r;
  logic [XLEN-1:0]  hi_wdata_r;
  logic [2*XLEN-1:0] load_cat_s;
`else
  logic             misalign_s;
`endif

  logic [OFF_W-1:0]    off_s;
  logic [LANE_W-1:0]   be_lane_s;
  logic [8*LANE_W-1:0] wdata_lane_s;
  logic                err_s;
  logic                nop_s;
  logic                accept_s;
  logic [XLEN-1:0]     load_lane_s;
  logic [XLEN-1:0]     rdata_next_s;

  // Request decode: lane position, byte enables, store alignment, error checks.
  always_comb begin
    off_s        = bus.req_addr_i[OFF_W-1:0];
    be_lane_s    = ~({LANE_W{1'b1}} << (4'd1 << bus.req_size_i)) << off_s;
    wdata_lane_s = {{(8*LANE_W-XLEN){1'b0}}, bus.req_wdata_i} << {off_s, 3'b000};
    nop_s        = !bus.req_rd_i && !bus.req_wr_i;
    accept_s     = bus.req_valid_i && (state_r == ST_IDLE);
`ifdef LSU_MISALIGN_SPLIT_EN
    err_s = (bus.req_rd_i && bus.req_wr_i) ||
            ((XLEN == 32) && (bus.req_size_i == 2'd3));
`else
    misalign_s = |(off_s & OFF_W'((4'd1 << bus.req_size_i) - 4'd1));
    err_s = (bus.req_rd_i && bus.req_wr_i) ||
            ((XLEN == 32) && (bus.req_size_i == 2'd3)) || misalign_s;
`endif
  end

  // Load path: select the addressed bytes (merging both beats when split).
  always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
    // Single-beat accesses never reach the upper copy's bytes after extension.
    if (state_r == ST_ACCESS2) begin
      load_cat_s = {bus.drdata_i, lo_data_r};
    end else begin
      load_cat_s = {bus.drdata_i, bus.drdata_i};
    end
    load_lane_s = load_cat_s[{off_r, 3'b000} +: XLEN];
`else
    load_lane_s = bus.drdata_i >> {off_r, 3'b000};
`endif
    if (rd_r) begin
      rdata_next_s = extend_load(load_lane_s, size_r, sgn_r);
    end else begin
      rdata_next_s = {XLEN{1'b0}};
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r             <= ST_IDLE;
      rd_r                <= 1'b0;
      wr_r                <= 1'b0;
      sgn_r               <= 1'b0;
      size_r              <= 2'd0;
      off_r               <= '0;
      idx_r               <= 5'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_r             <= 1'b0;
      lo_data_r           <= '0;
      hi_be_r             <= '0;
      hi_wdata_r          <= '0;
`endif
      bus.req_ready_o     <= 1'b1;
      bus.daddr_o         <= '0;
      bus.dwdata_o        <= '0;
      bus.dbe_o           <= '0;
      bus.drd_o           <= 1'b0;
      bus.dwr_o           <= 1'b0;
      bus.resp_valid_o    <= 1'b0;
      bus.resp_rdata_o    <= '0;
      bus.resp_rd_index_o <= 5'd0;
      bus.resp_err_o      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            rd_r            <= bus.req_rd_i;
            wr_r            <= bus.req_wr_i;
            sgn_r           <= bus.req_signed_i;
            size_r          <= bus.req_size_i;
            off_r           <= off_s;
            idx_r           <= bus.req_rd_index_i;
            bus.req_ready_o <= 1'b0;
            if (err_s || nop_s) begin
              // No bus beat: answer straight away.
              state_r             <= ST_RESP;
              bus.resp_valid_o    <= 1'b1;
              bus.resp_err_o      <= err_s;
              bus.resp_rdata_o    <= '0;
              bus.resp_rd_index_o <= bus.req_rd_index_i;
            end else begin
              state_r      <= ST_ACCESS;
              bus.daddr_o  <= {bus.req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              bus.dbe_o    <= be_lane_s[BE_W-1:0];
              bus.dwdata_o <= bus.req_wr_i ? wdata_lane_s[XLEN-1:0] : {XLEN{1'b0}};
              bus.drd_o    <= bus.req_rd_i;
              bus.dwr_o    <= bus.req_wr_i;
`ifdef LSU_MISALIGN_SPLIT_EN
              split_r      <= |be_lane_s[LANE_W-1:BE_W];
              hi_be_r      <= be_lane_s[LANE_W-1:BE_W];
              hi_wdata_r   <= bus.req_wr_i ? wdata_lane_s[8*LANE_W-1:XLEN] : {XLEN{1'b0}};
`endif
            end
          end
        end
        ST_ACCESS: begin
          if (bus.dready_i) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (split_r) begin
              // Strobes stay up; the second beat targets the next word.
              state_r      <= ST_ACCESS2;
              lo_data_r    <= bus.drdata_i;
              bus.daddr_o  <= bus.daddr_o + ADDR_W'(BE_W);
              bus.dbe_o    <= hi_be_r;
              bus.dwdata_o <= hi_wdata_r;
            end else begin
              state_r             <= ST_RESP;
              bus.daddr_o         <= '0;
              bus.dwdata_o        <= '0;
              bus.dbe_o           <= '0;
              bus.drd_o           <= 1'b0;
              bus.dwr_o           <= 1'b0;
              bus.resp_valid_o    <= 1'b1;
              bus.resp_err_o      <= 1'b0;
              bus.resp_rdata_o    <= rdata_next_s;
              bus.resp_rd_index_o <= idx_r;
            end
`else
            state_r             <= ST_RESP;
            bus.daddr_o         <= '0;
            bus.dwdata_o        <= '0;
            bus.dbe_o           <= '0;
            bus.drd_o           <= 1'b0;
            bus.dwr_o           <= 1'b0;
            bus.resp_valid_o    <= 1'b1;
            bus.resp_err_o      <= 1'b0;
            bus.resp_rdata_o    <= rdata_next_s;
            bus.resp_rd_index_o <= idx_r;
`endif
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ST_ACCESS2: begin
          if (bus.dready_i) begin
            state_r             <= ST_RESP;
            bus.daddr_o         <= '0;
            bus.dwdata_o        <= '0;
            bus.dbe_o           <= '0;
            bus.drd_o           <= 1'b0;
            bus.dwr_o           <= 1'b0;
            bus.resp_valid_o    <= 1'b1;
            bus.resp_err_o      <= 1'b0;
            bus.resp_rdata_o    <= rdata_next_s;
            bus.resp_rd_index_o <= idx_r;
          end
        end
`endif
        ST_RESP: begin
          state_r             <= ST_IDLE;
          bus.req_ready_o     <= 1'b1;
          bus.resp_valid_o    <= 1'b0;
          bus.resp_err_o      <= 1'b0;
          bus.resp_rdata_o    <= '0;
          bus.resp_rd_index_o <= 5'd0;
        end
        default: begin
          state_r             <= ST_IDLE;
          bus.req_ready_o     <= 1'b1;
          bus.daddr_o         <= '0;
          bus.dwdata_o        <= '0;
          bus.dbe_o           <= '0;
          bus.drd_o           <= 1'b0;
          bus.dwr_o           <= 1'b0;
          bus.resp_valid_o    <= 1'b0;
          bus.resp_err_o      <= 1'b0;
          bus.resp_rdata_o    <= '0;
          bus.resp_rd_index_o <= 5'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_access_unit
// Directed self-checking bench: a table of load/store vectors with
// hand-computed bus and response values, plus hand-written sequences for
// split/misaligned access, reset during ACCESS and an XLEN=64 instance.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_lsu_mem_access_unit;
  logic clk = 1'b0;
  logic reset_i;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu_mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) b ();
  lsu_mem_access_unit_if #(.XLEN(64), .ADDR_W(32)) b64 ();

  lsu_mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (b)
  );

  lsu_mem_access_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (b64)
  );

  typedef struct {
    logic        rd, wr, sgn;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [4:0]  idx;
    logic [31:0] drdata;
    int          waits;
    logic        beat, err;
    logic [31:0] daddr;
    logic [3:0]  dbe;
    logic [31:0] dwdata, rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rd, logic wr, logic sgn, logic [1:0] size,
                              logic [31:0] addr, logic [31:0] wdata, logic [4:0] idx,
                              logic [31:0] drdata, int waits, logic beat, logic err,
                              logic [31:0] daddr, logic [3:0] dbe,
                              logic [31:0] dwdata, logic [31:0] rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sgn = sgn; v.size = size; v.addr = addr;
    v.wdata = wdata; v.idx = idx; v.drdata = drdata; v.waits = waits;
    v.beat = beat; v.err = err; v.daddr = daddr; v.dbe = dbe;
    v.dwdata = dwdata; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    string t;
    t = $sformatf("v%0d", n);
    @(negedge clk);
    chk({t, " ready_idle"}, 64'(b.req_ready_o), 64'd1);
    b.req_rd_i = v.rd; b.req_wr_i = v.wr; b.req_signed_i = v.sgn;
    b.req_size_i = v.size; b.req_addr_i = v.addr; b.req_wdata_i = v.wdata;
    b.req_rd_index_i = v.idx; b.req_valid_i = 1'b1;
    @(negedge clk);
    // Scramble request fields: the unit must use what it latched.
    b.req_valid_i = 1'b0; b.req_addr_i = 32'hFFFF_FFFF; b.req_wdata_i = ~v.wdata;
    b.req_size_i = ~v.size; b.req_signed_i = ~v.sgn; b.req_rd_index_i = ~v.idx;
    if (v.beat) begin
      for (int w = 0; w <= v.waits; w++) begin
        chk({t, " drd"}, 64'(b.drd_o), 64'(v.rd));
        chk({t, " dwr"}, 64'(b.dwr_o), 64'(v.wr));
        chk({t, " daddr"}, 64'(b.daddr_o), 64'(v.daddr));
        chk({t, " dbe"}, 64'(b.dbe_o), 64'(v.dbe));
        chk({t, " dwdata"}, 64'(b.dwdata_o), 64'(v.dwdata));
        chk({t, " early_resp"}, 64'(b.resp_valid_o), 64'd0);
        chk({t, " ready_busy"}, 64'(b.req_ready_o), 64'd0);
        if (w == v.waits) begin
          b.dready_i = 1'b1; b.drdata_i = v.drdata;
        end
        @(negedge clk);
        b.dready_i = 1'b0; b.drdata_i = 32'h5A5A_5A5A;
      end
    end
    chk({t, " resp_valid"}, 64'(b.resp_valid_o), 64'd1);
    chk({t, " resp_err"}, 64'(b.resp_err_o), 64'(v.err));
    chk({t, " resp_rdata"}, 64'(b.resp_rdata_o), 64'(v.rdata));
    chk({t, " resp_idx"}, 64'(b.resp_rd_index_o), 64'(v.idx));
    chk({t, " strobes_off"}, 64'({b.drd_o, b.dwr_o}), 64'd0);
    @(negedge clk);
    chk({t, " resp_pulse"}, 64'(b.resp_valid_o), 64'd0);
    chk({t, " ready_back"}, 64'(b.req_ready_o), 64'd1);
  endtask

  task automatic run64(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                       input logic [63:0] drdata, input logic [31:0] daddr,
                       input logic [7:0] dbe, input logic [63:0] rdata);
    @(negedge clk);
    b64.req_rd_i = 1'b1; b64.req_wr_i = 1'b0; b64.req_signed_i = sgn;
    b64.req_size_i = size; b64.req_addr_i = addr; b64.req_rd_index_i = 5'd21;
    b64.req_valid_i = 1'b1;
    @(negedge clk);
    b64.req_valid_i = 1'b0;
    chk("x64 drd", 64'(b64.drd_o), 64'd1);
    chk("x64 daddr", 64'(b64.daddr_o), 64'(daddr));
    chk("x64 dbe", 64'(b64.dbe_o), 64'(dbe));
    b64.dready_i = 1'b1; b64.drdata_i = drdata;
    @(negedge clk);
    b64.dready_i = 1'b0;
    chk("x64 resp_valid", 64'(b64.resp_valid_o), 64'd1);
    chk("x64 resp_rdata", b64.resp_rdata_o, rdata);
    @(negedge clk);
    chk("x64 ready_back", 64'(b64.req_ready_o), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //        rd   wr   sgn  size  addr          wdata         idx    drdata        w  beat err  daddr         dbe      dwdata        rdata
    vecs.push_back(mk(1'b1,1'b0,1'b1,2'd0,32'h0000_1003,32'h0,        5'd1, 32'h80FF_FFFF,0,1'b1,1'b0,32'h0000_1000,4'b1000,32'h0,        32'hFFFF_FF80));
    vecs.push_back(mk(1'b1,1'b0,1'b0,2'd1,32'h0000_2002,32'h0,        5'd2, 32'hBEEF_1234,3,1'b1,1'b0,32'h0000_2000,4'b1100,32'h0,        32'h0000_BEEF));
    vecs.push_back(mk(1'b0,1'b1,1'b0,2'd0,32'h0000_3001,32'h0000_00AA,5'd3, 32'h0,        2,1'b1,1'b0,32'h0000_3000,4'b0010,32'h0000_AA00,32'h0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,2'd2,32'h0000_4000,32'h0,        5'd4, 32'h1234_5678,1,1'b1,1'b0,32'h0000_4000,4'b1111,32'h0,        32'h1234_5678));
    vecs.push_back(mk(1'b1,1'b0,1'b1,2'd1,32'h0000_5000,32'h0,        5'd5, 32'h0000_8001,0,1'b1,1'b0,32'h0000_5000,4'b0011,32'h0,        32'hFFFF_8001));
    vecs.push_back(mk(1'b1,1'b0,1'b0,2'd0,32'h0000_6002,32'h0,        5'd6, 32'h00C3_0000,0,1'b1,1'b0,32'h0000_6000,4'b0100,32'h0,        32'h0000_00C3));
    vecs.push_back(mk(1'b0,1'b1,1'b0,2'd1,32'h0000_7002,32'h1234_ABCD,5'd7, 32'h0,        1,1'b1,1'b0,32'h0000_7000,4'b1100,32'hABCD_0000,32'h0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,2'd2,32'h0000_7004,32'hDEAD_BEEF,5'd8, 32'h0,        0,1'b1,1'b0,32'h0000_7004,4'b1111,32'hDEAD_BEEF,32'h0));
    vecs.push_back(mk(1'b1,1'b1,1'b0,2'd2,32'h0000_0100,32'h0000_0055,5'd9, 32'h0,        0,1'b0,1'b1,32'h0,        4'b0000,32'h0,        32'h0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,2'd3,32'h0000_0200,32'h0,        5'd10,32'h0,        0,1'b0,1'b1,32'h0,        4'b0000,32'h0,        32'h0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd2,32'h0000_0300,32'h0,        5'd11,32'h0,        0,1'b0,1'b0,32'h0,        4'b0000,32'h0,        32'h0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,2'd0,32'h0000_9000,32'h0,        5'd12,32'h0000_007F,5,1'b1,1'b0,32'h0000_9000,4'b0001,32'h0,        32'h0000_007F));
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back(mk(1'b1,1'b0,1'b0,2'd1,32'h0000_2001,32'h0,        5'd13,32'h00AB_CD00,0,1'b1,1'b0,32'h0000_2000,4'b0110,32'h0,        32'h0000_ABCD));
`else
    vecs.push_back(mk(1'b1,1'b0,1'b0,2'd1,32'h0000_2001,32'h0,        5'd13,32'h0,        0,1'b0,1'b1,32'h0,        4'b0000,32'h0,        32'h0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,2'd2,32'h0000_4002,32'h0,        5'd14,32'h0,        0,1'b0,1'b1,32'h0,        4'b0000,32'h0,        32'h0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,2'd2,32'h0000_7001,32'h1111_1111,5'd15,32'h0,        0,1'b0,1'b1,32'h0,        4'b0000,32'h0,        32'h0));
`endif

    reset_i = 1'b1;
    b.req_valid_i = 1'b0; b.req_rd_i = 1'b0; b.req_wr_i = 1'b0; b.req_signed_i = 1'b0;
    b.req_size_i = 2'd0; b.req_addr_i = 32'h0; b.req_wdata_i = 32'h0; b.req_rd_index_i = 5'd0;
    b.dready_i = 1'b0; b.drdata_i = 32'h0;
    b64.req_valid_i = 1'b0; b64.req_rd_i = 1'b0; b64.req_wr_i = 1'b0; b64.req_signed_i = 1'b0;
    b64.req_size_i = 2'd0; b64.req_addr_i = 32'h0; b64.req_wdata_i = 64'h0; b64.req_rd_index_i = 5'd0;
    b64.dready_i = 1'b0; b64.drdata_i = 64'h0;
    repeat (2) @(negedge clk);
    chk("rst ready", 64'(b.req_ready_o), 64'd1);
    chk("rst strobes", 64'({b.drd_o, b.dwr_o}), 64'd0);
    chk("rst dbe", 64'(b.dbe_o), 64'd0);
    chk("rst daddr", 64'(b.daddr_o), 64'd0);
    chk("rst resp_valid", 64'(b.resp_valid_o), 64'd0);
    chk("rst resp_err", 64'(b.resp_err_o), 64'd0);
    reset_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

`ifdef LSU_MISALIGN_SPLIT_EN
    // LW 0x4002 crossing a word boundary: two beats, merged response.
    @(negedge clk);
    b.req_rd_i = 1'b1; b.req_wr_i = 1'b0; b.req_signed_i = 1'b1; b.req_size_i = 2'd2;
    b.req_addr_i = 32'h0000_4002; b.req_rd_index_i = 5'd14; b.req_valid_i = 1'b1;
    @(negedge clk);
    b.req_valid_i = 1'b0;
    chk("split b1 daddr", 64'(b.daddr_o), 64'h4000);
    chk("split b1 dbe", 64'(b.dbe_o), 64'b1100);
    chk("split b1 drd", 64'(b.drd_o), 64'd1);
    b.dready_i = 1'b1; b.drdata_i = 32'h2222_5555;
    @(negedge clk);
    b.drdata_i = 32'h7777_1111;
    chk("split b2 daddr", 64'(b.daddr_o), 64'h4004);
    chk("split b2 dbe", 64'(b.dbe_o), 64'b0011);
    chk("split b2 drd", 64'(b.drd_o), 64'd1);
    chk("split no_early_resp", 64'(b.resp_valid_o), 64'd0);
    @(negedge clk);
    b.dready_i = 1'b0;
    chk("split resp_valid", 64'(b.resp_valid_o), 64'd1);
    chk("split resp_rdata", 64'(b.resp_rdata_o), 64'h1111_2222);
    chk("split resp_err", 64'(b.resp_err_o), 64'd0);
    @(negedge clk);
`endif

    // Reset during ACCESS: strobes drop, unit idle, no response.
    @(negedge clk);
    b.req_rd_i = 1'b1; b.req_wr_i = 1'b0; b.req_size_i = 2'd2;
    b.req_addr_i = 32'h0000_0100; b.req_rd_index_i = 5'd9; b.req_valid_i = 1'b1;
    @(negedge clk);
    b.req_valid_i = 1'b0;
    chk("abort drd_before", 64'(b.drd_o), 64'd1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("abort strobes", 64'({b.drd_o, b.dwr_o}), 64'd0);
    chk("abort ready", 64'(b.req_ready_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("abort no_resp", 64'(b.resp_valid_o), 64'd0);
      @(negedge clk);
    end

    run_vec(vecs[0], 100);

    run64(32'h0000_0008, 2'd2, 1'b1, 64'hAAAA_AAAA_8000_0000, 32'h8, 8'h0F, 64'hFFFF_FFFF_8000_0000);
    run64(32'h0000_000C, 2'd2, 1'b0, 64'h9000_0000_1234_5678, 32'h8, 8'hF0, 64'h0000_0000_9000_0000);
    run64(32'h0000_0010, 2'd3, 1'b1, 64'h8123_4567_89AB_CDEF, 32'h10, 8'hFF, 64'h8123_4567_89AB_CDEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
